ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction-fetch controller that owns the architectural program counter and is the consumer of the next-PC value. It holds PC as a 30-bit word address, issues fetch requests to instruction memory over a valid/ready request plus response-valid handshake, and presents each fetched instruction with its PC to decode. It advances sequentially by default and reloads from `NPC` when control asserts a redirect. Sits between the next-PC logic, instruction memory and the decode/control stage of the multi-cycle datapath.

## Interface
- `RESET_PC`, 30'h0000_0C00 (byte address 0x0000_3000), word address loaded into PC on reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `NPC`  in  [31:2]  next word address from next-PC logic; sampled only when `redirect` is high.
- `redirect`  in  1  taken branch/jump/jr: load PC from `NPC`, discard any in-flight or held instruction.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  [31:2]  fetch word address, always equal to the PC register.
- `imem_rdy`  in  1  memory accepts request; transfer occurs on `imem_req && imem_rdy`.
- `imem_rvalid`  in  1  response valid, one cycle, exactly one per accepted request, at least 1 cycle after acceptance.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `instr`  out  32  held instruction.
- `instr_pc`  out  [31:2]  word address of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` valid.
- `instr_ack`  in  1  decode consumes instruction; meaningful only while `instr_valid`.

## Operation
- States: BOOT, FETCH, WAIT, HOLD. Registers: `pc_q`, `kill_q`, `instr`, `instr_pc`.
- Reset: state BOOT, `pc_q`=RESET_PC, `kill_q`=0, `instr`=0, `instr_pc`=0; outputs `imem_req`=0, `instr_valid`=0, `imem_addr`=RESET_PC.
- BOOT: no request; next cycle -> FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc_q`.
  - accept (`imem_rdy`=1), no redirect -> WAIT.
  - accept with `redirect` -> `pc_q`<=`NPC`, `kill_q`<=1, -> WAIT.
  - no accept with `redirect` -> `pc_q`<=`NPC`, stay FETCH (address may change while `imem_rdy`=0).
- WAIT: `imem_req`=0.
  - `imem_rvalid` & `kill_q`=0 & no redirect -> `instr`<=`imem_rdata`, `instr_pc`<=`pc_q`, -> HOLD.
  - `imem_rvalid` & (`kill_q`=1 or `redirect`) -> drop data, `kill_q`<=0, `pc_q`<=`NPC` if `redirect`, -> FETCH.
  - no `imem_rvalid`, `redirect` -> `pc_q`<=`NPC`, `kill_q`<=1, stay WAIT.
- HOLD: `instr_valid`=1.
  - `instr_ack` & no redirect -> `pc_q`<=`pc_q`+1, -> FETCH.
  - `redirect` (with or without ack) -> `pc_q`<=`NPC`, -> FETCH; instruction dropped if not acked.
  - neither -> hold all state.
- PC arithmetic: 30-bit, +1 per word; 30'h3FFF_FFFF wraps to 0, no flag.
- `redirect` is ignored in BOOT.
- At most one request outstanding; `kill_q` is set only while a response is owed.

## Timing
- Minimum fetch loop is 3 cycles (FETCH accept, WAIT with `imem_rvalid` on the next cycle, HOLD acked). An instruction is therefore available no more often than once every 3 cycles.
- First `imem_req` is high in the 2nd rising edge after `rst` deasserts (BOOT lasts one cycle).
- `instr_valid` rises on the edge that captures `imem_rvalid`, and falls on the edge that samples `instr_ack` or `redirect`.
- Redirect-to-request: the new `NPC` appears on `imem_addr` in the cycle after `redirect`, unless a killed response is still owed. In that case `imem_req` waits for the response to drain.
- `rst` mid-transaction: immediate return to reset values. A response owed from before reset must not be issued by memory, because memory shares `rst`.

## Test plan
- Reset, `imem_rdy`=1, 1-cycle memory latency, `instr_ack` always 1: `imem_addr` sequence 0xC00, 0xC01, 0xC02; `instr_pc` matches; `instr_valid` pulses every 3 cycles.
- Backpressure: hold `instr_ack`=0 for 5 cycles in HOLD. `instr`/`instr_pc` must stay stable, `imem_req`=0, and no PC change.
- Redirect in WAIT (`NPC`=0x100), response 4 cycles later: the response is dropped, `instr_valid` stays 0, and the next request has `imem_addr`=0x100.
- Redirect coincident with acceptance in FETCH: `kill_q` is set, the old response is discarded, and the next fetch is to `NPC`.
- Redirect in HOLD without ack: `instr_valid` goes to 0 the next cycle and the next fetch is to `NPC`. Redirect together with ack: same result.
- Wrap: RESET_PC=30'h3FFF_FFFF, ack the first instruction; the next `imem_addr` must be 0.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the word-address PC, issues one fetch at a time
// to instruction memory, and holds each fetched instruction until decode consumes it.
module ifetch_ctrl #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] NPC,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    input  logic        imem_rdy,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:2] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ack
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [29:0] instr_pc_q, instr_pc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= 32'd0;
            instr_pc_q <= 30'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    state_d = WAIT;
                    // Accepted request now targets a stale PC; its response must be dropped.
                    if (redirect) begin
                        pc_d   = NPC;
                        kill_d = 1'b1;
                    end
                end else if (redirect) begin
                    pc_d = NPC;
                end
            end

            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = FETCH;
                        if (redirect) begin
                            pc_d = NPC;
                        end
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    pc_d   = NPC;
                    kill_d = 1'b1;
                end
            end

            HOLD: begin
                instr_valid = 1'b1;
                if (redirect) begin
                    pc_d    = NPC;
                    state_d = FETCH;
                end else if (instr_ack) begin
                    pc_d    = pc_q + 30'd1;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign instr_pc  = instr_pc_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl: a transaction-level memory and PC/instruction
// scoreboard predict every output each cycle; a second instance covers PC wrap.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:2] NPC;
    logic        redirect;
    logic        imem_req;
    logic [31:2] imem_addr;
    logic        imem_rdy;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:2] instr_pc;
    logic        instr_valid;
    logic        instr_ack;

    logic        w_rst;
    logic [31:2] w_npc;
    logic        w_redirect;
    logic        w_req;
    logic [31:2] w_addr;
    logic        w_rdy;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:2] w_ipc;
    logic        w_valid;
    logic        w_ack;

    int total = 0;
    int bad   = 0;

    localparam logic [29:0] RPC  = 30'h0000_0C00;
    localparam logic [29:0] WRPC = 30'h3FFF_FFFF;

    // reference state
    logic [29:0] m_pc;
    logic        m_valid;
    logic        m_boot;
    logic        o_pend;
    logic        o_live;
    logic [29:0] o_addr;
    int          o_cnt;
    int          n_deliv;

    always #5 clk = ~clk;

    ifetch_ctrl #(.RESET_PC(RPC)) u_dut (
        .clk(clk), .rst(rst), .NPC(NPC), .redirect(redirect),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ack(instr_ack)
    );

    ifetch_ctrl #(.RESET_PC(WRPC)) u_wrap (
        .clk(clk), .rst(w_rst), .NPC(w_npc), .redirect(w_redirect),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdy(w_rdy),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .instr(w_instr), .instr_pc(w_ipc), .instr_valid(w_valid),
        .instr_ack(w_ack)
    );

    function automatic logic [31:0] mdata(input logic [29:0] a);
        return {a, 2'b00} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        imem_rdy    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        instr_ack   = 1'b0;
        NPC         = 30'd0;
        @(negedge clk);
        @(negedge clk);
        chk_eq("rst_req",   32'(imem_req), 32'd0);
        chk_eq("rst_valid", 32'(instr_valid), 32'd0);
        chk_eq("rst_addr",  32'(imem_addr), 32'(RPC));
        chk_eq("rst_instr", instr, 32'd0);
        chk_eq("rst_ipc",   32'(instr_pc), 32'd0);
        rst     = 1'b0;
        m_pc    = RPC;
        m_valid = 1'b0;
        m_boot  = 1'b1;
        o_pend  = 1'b0;
        o_live  = 1'b0;
        o_cnt   = 0;
    endtask

    // One cycle: compare outputs to the model, drive inputs, advance the model past the edge.
    task automatic step(input int p_rdy, input int p_ack, input int p_redir, input int max_lat);
        logic exp_req, acc, rv, was_valid;
        exp_req = !m_boot && !o_pend && !m_valid;
        chk_eq("addr",  32'(imem_addr), 32'(m_pc));
        chk_eq("req",   32'(imem_req), 32'(exp_req));
        chk_eq("valid", 32'(instr_valid), 32'(m_valid));
        if (m_valid) begin
            chk_eq("ipc",   32'(instr_pc), 32'(m_pc));
            chk_eq("instr", instr, mdata(m_pc));
        end

        imem_rdy    = ($urandom_range(99) < p_rdy);
        rv          = o_pend && (o_cnt == 0);
        imem_rvalid = rv;
        imem_rdata  = rv ? mdata(o_addr) : $urandom;
        redirect    = !m_boot && ($urandom_range(99) < p_redir);
        NPC         = 30'($urandom);
        instr_ack   = ($urandom_range(99) < p_ack);

        acc       = exp_req && imem_rdy;
        was_valid = m_valid;
        if (m_valid && instr_ack && !redirect) n_deliv++;

        if (rv) begin
            o_pend = 1'b0;
        end else if (o_pend) begin
            o_cnt--;
            if (redirect) o_live = 1'b0;
        end
        if (acc) begin
            o_pend = 1'b1;
            o_addr = m_pc;
            o_live = !redirect;
            o_cnt  = $urandom_range(max_lat);
        end

        if (was_valid && (instr_ack || redirect)) m_valid = 1'b0;
        else if (rv && o_live && !redirect)       m_valid = 1'b1;

        if (redirect)                    m_pc = NPC;
        else if (was_valid && instr_ack) m_pc = m_pc + 30'd1;
        m_boot = 1'b0;

        @(negedge clk);
    endtask

    initial begin
        logic        w_acc;
        logic [29:0] w_last;

        rst = 1'b1;
        w_rst = 1'b1;
        w_npc = 30'd0;
        w_redirect = 1'b0;
        w_rdy = 1'b0;
        w_rvalid = 1'b0;
        w_rdata = 32'd0;
        w_ack = 1'b0;

        // streaming: always ready, single-cycle latency, always acked
        do_reset();
        n_deliv = 0;
        for (int i = 0; i < 60; i++) step(100, 100, 0, 0);
        chk_eq("stream_count", 32'(n_deliv), 32'd19);

        // backpressure and variable latency, no redirects
        n_deliv = 0;
        for (int i = 0; i < 400; i++) step(70, 30, 0, 4);
        chk_eq("bp_progress", 32'(n_deliv > 10), 32'd1);

        // redirects everywhere
        for (int i = 0; i < 800; i++) step(70, 60, 15, 4);

        // reset in the middle of traffic, then heavy redirect mix
        do_reset();
        for (int i = 0; i < 500; i++) step(50, 50, 35, 5);
        do_reset();
        for (int i = 0; i < 300; i++) step(90, 80, 5, 1);

        // PC wrap on a second instance
        @(negedge clk);
        w_rst = 1'b0;
        w_acc = 1'b0;
        w_last = 30'd0;
        for (int i = 0; i < 6; i++) begin
            w_rvalid   = w_acc;
            w_rdata    = mdata(w_last);
            w_rdy      = 1'b1;
            w_ack      = 1'b1;
            w_redirect = 1'b0;
            if (i == 1) begin
                chk_eq("wrap_req1",  32'(w_req), 32'd1);
                chk_eq("wrap_addr1", 32'(w_addr), 32'(WRPC));
            end
            if (i == 3) begin
                chk_eq("wrap_valid", 32'(w_valid), 32'd1);
                chk_eq("wrap_ipc",   32'(w_ipc), 32'(WRPC));
                chk_eq("wrap_instr", w_instr, mdata(WRPC));
            end
            if (i == 4) begin
                chk_eq("wrap_req2",  32'(w_req), 32'd1);
                chk_eq("wrap_addr2", 32'(w_addr), 32'd0);
            end
            w_acc  = w_req && w_rdy;
            w_last = w_addr;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
